// File: rtl/mux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arb
// Purpose  : C-channel data mux with round-robin or forced-select arbitration
//            and a one-word registered output stage with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module mux_rr_arb #(
  parameter int L = 16,
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<N)-1:0]     req,
  input  logic [(1<<N)*L-1:0]   din,
  input  logic                  mode,
  input  logic [N-1:0]          addr,
  output logic [(1<<N)-1:0]     gnt,
  output logic [L-1:0]          dout,
  output logic [N-1:0]          out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           xfer_cnt
);

  localparam int C = 1 << N;

  logic [N-1:0]  ptr_q, ptr_d;
  logic [L-1:0]  dout_q, dout_d;
  logic [N-1:0]  out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;

  logic [L-1:0]  ch_data [C];
  logic [N-1:0]  rr_ch;
  logic          rr_found;
  logic [N-1:0]  rr_idx;
  logic [N-1:0]  sel_ch;
  logic          sel_vld;
  logic          accept;
  logic          deliver;

  for (genvar i = 0; i < C; i++) begin : g_unpack
    assign ch_data[i] = din[i*L +: L];
  end

  // Search starts one past the last winner; N-bit addition gives the modulo-C wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_idx   = '0;
    for (int k = 1; k <= C; k++) begin
      rr_idx = ptr_q + N'(k);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_ch    = rr_idx;
      end
    end
  end

  assign sel_ch  = mode ? addr : rr_ch;
  assign sel_vld = mode ? req[addr] : rr_found;
  assign accept  = sel_vld && (!out_valid_q || out_ready);
  assign deliver = out_valid_q && out_ready;

  // gnt is masked by rst_n so it is quiet while the block is held in reset.
  assign gnt = (accept && rst_n) ? (C'(1) << sel_ch) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    dout_d      = dout_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (accept) begin
      ptr_d       = sel_ch;
      dout_d      = ch_data[sel_ch];
      out_ch_d    = sel_ch;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
    if (deliver) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= {N{1'b1}};
      dout_q      <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      dout_q      <= dout_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arb
// Purpose  : Self-checking bench for mux_rr_arb using a reference arbiter
//            model and a scoreboard of accepted words awaiting delivery.
// Revision : 1.0
// ============================================================================
module tb_mux_rr_arb;

  localparam int L = 16;
  localparam int N = 2;
  localparam int C = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [C-1:0]    req = '0;
  logic [C*L-1:0]  din = '0;
  logic            mode = 1'b0;
  logic [N-1:0]    addr = '0;
  logic [C-1:0]    gnt;
  logic [L-1:0]    dout;
  logic [N-1:0]    out_ch;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     xfer_cnt;

  mux_rr_arb #(.L(L), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .mode(mode), .addr(addr),
    .gnt(gnt), .dout(dout), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of accepted-but-undelivered words, and the reference state.
  logic [N-1:0]  sb_ch [$];
  logic [L-1:0]  sb_data [$];
  int            ptr_m;
  logic          ov_m;
  logic [15:0]   cnt_m;
  logic [C-1:0]  last_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_din(input int ch, input logic [L-1:0] val);
    din[ch*L +: L] = val;
  endtask

  task automatic model_reset();
    ptr_m = C - 1;
    ov_m  = 1'b0;
    cnt_m = '0;
    sb_ch.delete();
    sb_data.delete();
  endtask

  function automatic int model_pick();
    if (mode) return req[addr] ? int'(addr) : -1;
    for (int k = 1; k <= C; k++) begin
      int i;
      i = (ptr_m + k) % C;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check combinational/held outputs mid-cycle, then advance the model.
  task automatic cycle();
    int            ch;
    logic          acc;
    logic          dlv;
    logic [C-1:0]  exp_gnt;
    @(negedge clk);
    ch      = model_pick();
    acc     = (ch >= 0) && (!ov_m || out_ready);
    dlv     = ov_m && out_ready;
    exp_gnt = acc ? (C'(1) << ch) : '0;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("out_valid", 32'(out_valid), 32'(ov_m));
    check("sb_level", sb_ch.size(), ov_m ? 1 : 0);
    if (ov_m && sb_ch.size() > 0) begin
      check("dout", 32'(dout), 32'(sb_data[0]));
      check("out_ch", 32'(out_ch), 32'(sb_ch[0]));
    end
    last_gnt = gnt;
    if (dlv && sb_ch.size() > 0) begin
      void'(sb_ch.pop_front());
      void'(sb_data.pop_front());
    end
    if (acc) begin
      sb_ch.push_back(ch[N-1:0]);
      sb_data.push_back(din[ch*L +: L]);
    end
    @(posedge clk);
    #1;
    if (acc) ptr_m = ch;
    ov_m = acc ? 1'b1 : (dlv ? 1'b0 : ov_m);
    if (dlv) cnt_m = cnt_m + 16'd1;
    check("xfer_cnt", 32'(xfer_cnt), 32'(cnt_m));
  endtask

  logic [C-1:0] rr_gnt_tab [8];
  logic [L-1:0] alt_tab [6];
  int budget;

  initial begin
    rr_gnt_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    alt_tab    = '{16'h1111, 16'h3333, 16'h1111, 16'h3333, 16'h1111, 16'h3333};
    model_reset();

    // Reset state, with requests present to show gnt stays quiet.
    req = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_cnt", 32'(xfer_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin over all four channels.
    for (int i = 0; i < C; i++) set_din(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_gnt", 32'(last_gnt), 32'(rr_gnt_tab[i]));
    end
    check("rr_cnt7", 32'(xfer_cnt), 32'd7);

    // Sparse requests alternate between ch1 and ch3.
    req = 4'b1010;
    set_din(1, 16'h1111);
    set_din(3, 16'h3333);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("alt_no_g0", 32'(last_gnt[0]), 32'h0);
      check("alt_no_g2", 32'(last_gnt[2]), 32'h0);
      check("alt_dout", 32'(dout), 32'(alt_tab[i]));
    end

    // Forced select: only addr counts.
    req = 4'b0000;
    cycle();
    mode = 1'b1;
    addr = 2'd2;
    req  = 4'b1011;
    cycle();
    check("frc_gnt_none", 32'(last_gnt), 32'h0);
    check("frc_valid0", 32'(out_valid), 32'h0);
    req = 4'b1111;
    set_din(2, 16'hBEEF);
    cycle();
    check("frc_gnt2", 32'(last_gnt), 32'b0100);
    check("frc_dout", 32'(dout), 32'hBEEF);
    check("frc_out_ch", 32'(out_ch), 32'd2);

    // Stall holds the word; release gives delivery and accept in one cycle.
    mode = 1'b0;
    req  = 4'b0000;
    cycle();
    req = 4'b0001;
    set_din(0, 16'hA5A5);
    cycle();
    req = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_gnt", 32'(last_gnt), 32'h0);
      check("stall_dout", 32'(dout), 32'hA5A5);
    end
    out_ready = 1'b1;
    cycle();
    check("release_gnt", 32'(last_gnt), 32'b0010);
    check("release_out_ch", 32'(out_ch), 32'd1);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_dout", 32'(dout), 32'h0);
    check("arst_cnt", 32'(xfer_cnt), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;
    cycle();
    check("post_rst_gnt", 32'(last_gnt), 32'b0001);

    // Run traffic until the delivery counter reaches its top value, then wrap.
    budget = 70000;
    while (cnt_m != 16'hFFFF && budget > 0) begin
      cycle();
      budget--;
    end
    check("preload_budget", 32'(cnt_m), 32'hFFFF);
    check("cnt_top", 32'(xfer_cnt), 32'hFFFF);
    cycle();
    check("cnt_wrap", 32'(xfer_cnt), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 The block SHALL have parameter L, default 16, meaning data width in bits per channel.
REQ-002 The block SHALL have parameter N, default 2, meaning select bits; channel count C = 2^N.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req  input  C  per-channel request; bit i = channel i holds valid data.
REQ-006 The block SHALL have port din  input  C*L  packed channel data; channel i at bits [i*L+L-1 : i*L].
REQ-007 The block SHALL have port mode  input  1  0 = round-robin arbitration, 1 = forced select.
REQ-008 The block SHALL have port addr  input  N  channel index used when mode = 1.
REQ-009 The block SHALL have port gnt  output  C  one-hot, combinational; bit i high in the cycle channel i is accepted.
REQ-010 The block SHALL have port dout  output  L  registered selected data.
REQ-011 The block SHALL have port out_ch  output  N  registered index of the channel held in dout.
REQ-012 The block SHALL have port out_valid  output  1  dout/out_ch hold an undelivered word.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts dout this cycle.
REQ-014 The block SHALL have port xfer_cnt  output  16  count of words delivered downstream.

Function
REQ-015 Accept condition SHALL be: candidate channel exists AND (out_valid = 0 OR out_ready = 1).
REQ-016 Delivery SHALL occur in any cycle with out_valid = 1 and out_ready = 1.
REQ-017 Round-robin mode SHALL choose the first i with req[i] = 1, searching ptr+1, ptr+2, ... modulo C (wrap C-1 -> 0).
REQ-018 Forced mode SHALL consider only channel addr; req[addr] = 0 means no accept, regardless of other requests.
REQ-019 On accept, dout SHALL load din[ch], out_ch SHALL load ch, out_valid SHALL be 1 on the next edge, gnt[ch] = 1 that cycle.
REQ-020 On accept in either mode, ptr SHALL load ch; otherwise ptr SHALL hold.
REQ-021 Delivery without accept SHALL clear out_valid; dout and out_ch SHALL hold their values.
REQ-022 Simultaneous delivery and accept SHALL give back-to-back throughput: new word loaded, out_valid stays 1, one word per cycle.
REQ-023 With out_valid = 1 and out_ready = 0 (stall), dout, out_ch, out_valid, ptr SHALL hold and gnt SHALL be all-zero.
REQ-024 gnt SHALL be all-zero whenever no accept occurs; gnt SHALL never have more than one bit set.
REQ-025 xfer_cnt SHALL increment by 1 per delivery and wrap 0xFFFF -> 0x0000.
REQ-026 A requester SHALL hold req and din stable until it sees its gnt bit; the block SHALL sample din only in the accept cycle.
REQ-027 mode/addr changes SHALL take effect in the same cycle (combinational selection), with no effect on a held output word.
REQ-028 Latency SHALL be one cycle from accept to out_valid = 1.

Reset
REQ-029 rst_n = 0 SHALL immediately force out_valid = 0, dout = 0, out_ch = 0, xfer_cnt = 0, ptr = C-1, independent of clk.
REQ-030 gnt SHALL be all-zero while rst_n = 0.
REQ-031 Reset asserted mid-stall SHALL discard the held word; no delivery is counted.
REQ-032 After rst_n deasserts, the first round-robin accept SHALL favour channel 0.

Verification
REQ-033 C=4, L=16, mode=0, req=4'b1111, out_ready=1 for 8 cycles -> gnt 0001,0010,0100,1000,0001...; out_ch 0,1,2,3,0... one cycle later; xfer_cnt = 7 after 8 cycles (first word delivered on cycle 2).
REQ-034 mode=0, req=4'b1010, din ch1=0x1111 ch3=0x3333, out_ready=1 -> dout 0x1111 then 0x3333 alternating; gnt never 0001 or 0100.
REQ-035 mode=1, addr=2, req=4'b1011 -> gnt = 0000, out_valid stays 0; set req[2]=1, din ch2=0xBEEF -> gnt = 0100, next cycle dout = 0xBEEF, out_ch = 2.
REQ-036 Accept 0xA5A5 from ch0, hold out_ready=0 for 5 cycles with req=4'b1111 -> dout = 0xA5A5, gnt = 0000 throughout; release out_ready -> delivery plus accept of ch1 in the same cycle.
REQ-037 Preload xfer_cnt to 0xFFFF by continuous traffic, one more delivery -> xfer_cnt = 0x0000.
REQ-038 Assert rst_n = 0 between clock edges during a stall -> out_valid, dout, xfer_cnt = 0 immediately; after release, req=4'b1111 -> first gnt = 0001.
